// File: rtl/nic_pkg.sv
// Shared constants for the processor-to-mesh network interface.
package nic_pkg;

    localparam int unsigned NIC_DATA_WIDTH = 64;
    localparam int unsigned NIC_ADDR_WIDTH = 2;

    localparam logic [1:0] NIC_IN_DATA    = 2'b00;
    localparam logic [1:0] NIC_IN_STATUS  = 2'b01;
    localparam logic [1:0] NIC_OUT_DATA   = 2'b10;
    localparam logic [1:0] NIC_OUT_STATUS = 2'b11;

endpackage

// File: rtl/nic_fifo.sv
// Small synchronous FIFO with a combinational head; pushes while full and
// pops while empty are ignored.
module nic_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [0:WIDTH-1] din,
    output logic [0:WIDTH-1] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [0:WIDTH-1] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cpu_network_interface.sv
// Memory-mapped NIC: processor writes queue packets for injection into the
// mesh, processor reads drain ejected packets and poll FIFO status.
module cpu_network_interface
    import nic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NIC_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ADDR_WIDTH = NIC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    logic [0:DATA_WIDTH-1] in_head, out_head;
    logic                  in_full, in_empty, out_full, out_empty;
    logic                  rd_en, wr_en;
    logic                  in_push, in_pop, out_push, out_pop;

    logic [0:DATA_WIDTH-1] d_out_q, d_out_d;
    logic [0:DATA_WIDTH-1] net_do_q, net_do_d;
    logic                  net_so_q, net_so_d;

    assign rd_en = nicEn && !nicWrEn;
    assign wr_en = nicEn && nicWrEn;

    // Eject side: router pushes, processor pops via IN_DATA reads.
    assign net_ri   = reset && !in_full;
    assign in_push  = net_si && net_ri;
    assign in_pop   = rd_en && (addr == ADDR_WIDTH'(NIC_IN_DATA)) && !in_empty;

    // Inject side: processor pushes, router drains during the even phase.
    assign out_push = wr_en && (addr == ADDR_WIDTH'(NIC_OUT_DATA)) && !out_full;
    assign out_pop  = !out_empty && net_ro && !net_polarity;

    nic_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .din   (net_di),
        .dout  (in_head),
        .full  (in_full),
        .empty (in_empty)
    );

    nic_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .pop   (out_pop),
        .din   (d_in),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    always_comb begin
        d_out_d  = d_out_q;
        net_so_d = out_pop;
        net_do_d = out_pop ? out_head : net_do_q;
        if (rd_en) begin
            case (addr)
                ADDR_WIDTH'(NIC_IN_DATA):    d_out_d = in_empty ? '0 : in_head;
                ADDR_WIDTH'(NIC_IN_STATUS):  d_out_d = {{(DATA_WIDTH-1){1'b0}}, !in_empty};
                ADDR_WIDTH'(NIC_OUT_STATUS): d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:                     d_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_out_q  <= '0;
            net_so_q <= 1'b0;
            net_do_q <= '0;
        end else begin
            d_out_q  <= d_out_d;
            net_so_q <= net_so_d;
            net_do_q <= net_do_d;
        end
    end

    assign d_out  = d_out_q;
    assign net_so = net_so_q;
    assign net_do = net_do_q;

endmodule

// File: tb/tb_cpu_network_interface.sv
// Directed self-checking bench for cpu_network_interface.
module tb_cpu_network_interface;

    logic        clk;
    logic        reset;
    logic        nicEn;
    logic        nicWrEn;
    logic [1:0]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int checks   = 0;
    int failures = 0;

    cpu_network_interface dut (
        .clk          (clk),
        .reset        (reset),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        cycle();
        nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        cycle();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; net_si = 1'b1; net_di = 64'h77; net_ro = 1'b1; net_polarity = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h99;
        cycle();
        cycle();
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL reset_d_out got=%h exp=0", d_out); end
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL reset_net_so got=%b exp=0", net_so); end
        checks++; if (net_do !== 64'h0) begin failures++; $display("FAIL reset_net_do got=%h exp=0", net_do); end
        checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL reset_net_ri got=%b exp=0", net_ri); end
        nicEn = 1'b0; nicWrEn = 1'b0; net_si = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL post_reset_net_ri got=%b exp=1", net_ri); end
        rd(2'b01);
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL post_reset_in_status got=%h exp=0", d_out); end
        rd(2'b11);
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL post_reset_out_status got=%h exp=0", d_out); end
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL post_reset_no_inject got=%b exp=0", net_so); end
    endtask

    task automatic test_inject();
        net_ro = 1'b1; net_polarity = 1'b0;
        wr(2'b10, 64'hDEAD_BEEF_0000_0001);
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL inject_early got=%b exp=0", net_so); end
        cycle();
        checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL inject_so got=%b exp=1", net_so); end
        checks++; if (net_do !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL inject_do got=%h exp=deadbeef00000001", net_do); end
        cycle();
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL inject_pulse_width got=%b exp=0", net_so); end
        rd(2'b11);
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL inject_out_status got=%h exp=0", d_out); end
    endtask

    task automatic test_back_pressure();
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(2'b10, 64'h1);
        wr(2'b10, 64'h2);
        rd(2'b11);
        checks++; if (d_out !== 64'h1) begin failures++; $display("FAIL bp_out_full got=%h exp=1", d_out); end
        wr(2'b10, 64'h3);
        checks++; if (d_out !== 64'h1) begin failures++; $display("FAIL bp_write_keeps_d_out got=%h exp=1", d_out); end
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL bp_no_inject got=%b exp=0", net_so); end
        net_ro = 1'b1;
        cycle();
        checks++; if (net_so !== 1'b1 || net_do !== 64'h1) begin failures++; $display("FAIL bp_first so=%b do=%h exp so=1 do=1", net_so, net_do); end
        cycle();
        checks++; if (net_so !== 1'b1 || net_do !== 64'h2) begin failures++; $display("FAIL bp_second so=%b do=%h exp so=1 do=2", net_so, net_do); end
        cycle();
        checks++; if (net_so !== 1'b0 || net_do !== 64'h2) begin failures++; $display("FAIL bp_drained so=%b do=%h exp so=0 do=2", net_so, net_do); end
        cycle();
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL bp_no_third got=%b exp=0", net_so); end
    endtask

    task automatic test_polarity();
        net_ro = 1'b1; net_polarity = 1'b1;
        wr(2'b10, 64'h5);
        for (int i = 0; i < 3; i++) begin
            checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL polarity_hold_%0d got=%b exp=0", i, net_so); end
            if (i < 2) cycle();
        end
        net_polarity = 1'b0;
        cycle();
        checks++; if (net_so !== 1'b1 || net_do !== 64'h5) begin failures++; $display("FAIL polarity_release so=%b do=%h exp so=1 do=5", net_so, net_do); end
        cycle();
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL polarity_single got=%b exp=0", net_so); end
    endtask

    task automatic test_eject();
        net_si = 1'b1; net_di = 64'hA;
        cycle();
        net_di = 64'hB;
        cycle();
        checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL eject_ri_full got=%b exp=0", net_ri); end
        net_di = 64'hE;
        cycle();
        checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL eject_ri_still_full got=%b exp=0", net_ri); end
        net_si = 1'b0;
        rd(2'b01);
        checks++; if (d_out !== 64'h1) begin failures++; $display("FAIL eject_status got=%h exp=1", d_out); end
        rd(2'b00);
        checks++; if (d_out !== 64'hA) begin failures++; $display("FAIL eject_first got=%h exp=a", d_out); end
        checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL eject_ri_freed got=%b exp=1", net_ri); end
        rd(2'b00);
        checks++; if (d_out !== 64'hB) begin failures++; $display("FAIL eject_second got=%h exp=b", d_out); end
        rd(2'b01);
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL eject_status_empty got=%h exp=0", d_out); end
        rd(2'b00);
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL eject_empty_read got=%h exp=0", d_out); end
        rd(2'b10);
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL out_data_read got=%h exp=0", d_out); end
    endtask

    task automatic test_simultaneous();
        net_si = 1'b1; net_di = 64'hC;
        cycle();
        net_di = 64'hD;
        rd(2'b00);
        net_si = 1'b0;
        checks++; if (d_out !== 64'hC) begin failures++; $display("FAIL simul_pop got=%h exp=c", d_out); end
        rd(2'b01);
        checks++; if (d_out !== 64'h1) begin failures++; $display("FAIL simul_status got=%h exp=1", d_out); end
        rd(2'b00);
        checks++; if (d_out !== 64'hD) begin failures++; $display("FAIL simul_second got=%h exp=d", d_out); end
        net_si = 1'b1; net_di = 64'hF;
        rd(2'b00);
        net_si = 1'b0;
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL empty_pop_with_push got=%h exp=0", d_out); end
        rd(2'b00);
        checks++; if (d_out !== 64'hF) begin failures++; $display("FAIL empty_pop_push_lands got=%h exp=f", d_out); end
    endtask

    task automatic test_reset_mid();
        net_si = 1'b1; net_di = 64'h11;
        cycle();
        net_di = 64'h12;
        cycle();
        net_si = 1'b0;
        rd(2'b00);
        checks++; if (d_out !== 64'h11) begin failures++; $display("FAIL mid_pre_read got=%h exp=11", d_out); end
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(2'b10, 64'h21);
        wr(2'b10, 64'h22);
        net_ro = 1'b1;
        cycle();
        checks++; if (net_so !== 1'b1 || net_do !== 64'h21) begin failures++; $display("FAIL mid_inject so=%b do=%h exp so=1 do=21", net_so, net_do); end
        reset = 1'b0; net_si = 1'b1; net_di = 64'h33;
        #1;
        checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL mid_reset_ri got=%b exp=0", net_ri); end
        cycle();
        checks++; if (net_so !== 1'b0 || net_do !== 64'h0 || d_out !== 64'h0) begin failures++; $display("FAIL mid_reset_outputs so=%b do=%h dout=%h exp all 0", net_so, net_do, d_out); end
        cycle();
        net_si = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL mid_release_ri got=%b exp=1", net_ri); end
        cycle();
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL mid_out_discarded got=%b exp=0", net_so); end
        rd(2'b01);
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL mid_in_status got=%h exp=0", d_out); end
        rd(2'b11);
        checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL mid_out_status got=%h exp=0", d_out); end
        checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL mid_no_late_inject got=%b exp=0", net_so); end
    endtask

    initial begin
        reset = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        test_reset();
        test_inject();
        test_back_pressure();
        test_polarity();
        test_eject();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
